// File: rtl/axis_pkt_arbiter_2to1.sv
// axis_pkt_arbiter_2to1: packet-atomic round-robin merge of two AXI-Stream sources into one registered output
module axis_pkt_arbiter_2to1 #(
  parameter int DWIDTH = 16,
  parameter int CWIDTH = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  input  logic                s_a_tvalid,
  output logic                s_a_tready,
  input  logic                s_a_tlast,
  input  logic [DWIDTH-1:0]   s_a_tdata,
  input  logic                s_b_tvalid,
  output logic                s_b_tready,
  input  logic                s_b_tlast,
  input  logic [DWIDTH-1:0]   s_b_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [DWIDTH-1:0]   m_tdata,
  output logic [DWIDTH/8-1:0] m_tkeep,
  output logic                m_tid,
  output logic [CWIDTH-1:0]   pkt_cnt_a,
  output logic [CWIDTH-1:0]   pkt_cnt_b
);
  localparam logic [1:0] IDLE = 2'd0, GNT_A = 2'd1, GNT_B = 2'd2;
  logic [1:0] state, state_nxt;
  logic       rr_ptr, out_free, acc_a, acc_b, end_a, end_b;
  assign m_tkeep    = '1;
  assign out_free   = !m_tvalid || m_tready;
  assign s_a_tready = (state == GNT_A) && out_free;
  assign s_b_tready = (state == GNT_B) && out_free;
  assign acc_a      = s_a_tvalid && s_a_tready;
  assign acc_b      = s_b_tvalid && s_b_tready;
  assign end_a      = acc_a && s_a_tlast;
  assign end_b      = acc_b && s_b_tlast;
  // pick a source in IDLE (rr_ptr breaks ties); hold the grant until that source's last beat is taken
  always_comb begin
    state_nxt = (state == IDLE) ? ((s_a_tvalid && (!s_b_tvalid || !rr_ptr)) ? GNT_A : s_b_tvalid ? GNT_B : IDLE)
              : (end_a || end_b) ? IDLE : state;
  end
  // grant state, round-robin pointer and per-source completed-packet counters
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      pkt_cnt_a <= '0;
      pkt_cnt_b <= '0;
    end else begin
      state <= state_nxt;
      if (end_a) begin
        rr_ptr    <= 1'b1;
        pkt_cnt_a <= pkt_cnt_a + CWIDTH'(1);
      end
      if (end_b) begin
        rr_ptr    <= 1'b0;
        pkt_cnt_b <= pkt_cnt_b + CWIDTH'(1);
      end
    end
  end
  // single output register: load on accept, drop valid once the sink takes the beat
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tid    <= 1'b0;
      m_tdata  <= '0;
    end else if (acc_a || acc_b) begin
      m_tvalid <= 1'b1;
      m_tid    <= acc_b;
      m_tdata  <= acc_b ? s_b_tdata : s_a_tdata;
      m_tlast  <= acc_b ? s_b_tlast : s_a_tlast;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_pkt_arbiter_2to1.sv
// tb_axis_pkt_arbiter_2to1: randomized packet traffic checked against a packet-level round-robin model
module tb_axis_pkt_arbiter_2to1;
  localparam int DW = 16, CW = 4;
  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic t; logic [DW-1:0] d; logic l;} obeat_t;
  logic ap_clk = 0, ap_rst_n = 0;
  logic s_a_tvalid = 0, s_a_tready, s_a_tlast = 0;
  logic s_b_tvalid = 0, s_b_tready, s_b_tlast = 0;
  logic [DW-1:0] s_a_tdata = '0, s_b_tdata = '0, m_tdata;
  logic m_tvalid, m_tready = 0, m_tlast, m_tid;
  logic [DW/8-1:0] m_tkeep;
  logic [CW-1:0] pkt_cnt_a, pkt_cnt_b;
  int checks = 0, errors = 0, cyc = 0, deadline = 0, out_cnt = 0, stall_seen = 0;
  int pk_a = 0, pk_b = 0;
  int rdy_pct = 100, gap_pct = 0, gap_beat = -1, gap_len = 0, stall_after = 0, stall_len = 0;
  beat_t src_a[$], src_b[$], last_a[$], last_b[$];
  obeat_t exp_q[$];
  logic [DW+2:0] trace[$];
  bit trace_en = 0;

  axis_pkt_arbiter_2to1 #(.DWIDTH(DW), .CWIDTH(CW)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_a_tvalid(s_a_tvalid), .s_a_tready(s_a_tready), .s_a_tlast(s_a_tlast), .s_a_tdata(s_a_tdata),
    .s_b_tvalid(s_b_tvalid), .s_b_tready(s_b_tready), .s_b_tlast(s_b_tlast), .s_b_tdata(s_b_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tid(m_tid), .pkt_cnt_a(pkt_cnt_a), .pkt_cnt_b(pkt_cnt_b)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;
  always @(negedge ap_clk) if (trace_en) trace.push_back({m_tvalid, m_tid, m_tdata, m_tlast});

  task automatic cfg(input int r, input int gp, input int gb, input int gl, input int sa, input int sl);
    rdy_pct = r; gap_pct = gp; gap_beat = gb; gap_len = gl; stall_after = sa; stall_len = sl;
  endtask

  task automatic do_reset;
    s_a_tvalid = 0; s_b_tvalid = 0; m_tready = 0; ap_rst_n = 0;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1;
    pk_a = 0; pk_b = 0;
  endtask

  task automatic add_pkts(input bit sel, input int n, input int maxlen);
    for (int p = 0; p < n; p++) begin
      int len = $urandom_range(1, maxlen);
      for (int j = 0; j < len; j++) begin
        beat_t b;
        b.d = DW'($urandom);
        b.l = (j == len - 1);
        if (sel) src_b.push_back(b); else src_a.push_back(b);
      end
      if (sel) pk_b++; else pk_a++;
    end
  endtask

  // whole packets alternate between sources while both have one waiting, starting with A
  function automatic void build_exp;
    int ia = 0, ib = 0;
    bit turn = 0, pick;
    beat_t b;
    exp_q.delete();
    while (ia < src_a.size() || ib < src_b.size()) begin
      pick = (ia >= src_a.size()) ? 1'b1 : (ib >= src_b.size()) ? 1'b0 : turn;
      do begin
        b = pick ? src_b[ib] : src_a[ia];
        exp_q.push_back({pick, b.d, b.l});
        if (pick) ib++; else ia++;
      end while (!b.l && (pick ? ib < src_b.size() : ia < src_a.size()));
      turn = !pick;
    end
  endfunction

  task automatic set_src(input bit sel, input bit v, input beat_t b);
    if (sel) begin s_b_tvalid = v; s_b_tdata = b.d; s_b_tlast = b.l; end
    else begin s_a_tvalid = v; s_a_tdata = b.d; s_a_tlast = b.l; end
  endtask

  task automatic drive_src(input bit sel);
    int n = sel ? src_b.size() : src_a.size();
    int k = 0;
    bit acc;
    for (int i = 0; i < n; i++) begin
      beat_t b = sel ? src_b[i] : src_a[i];
      if (k > 0) begin
        int g = (!sel && k == gap_beat) ? gap_len : 0;
        while ((g > 0 || $urandom_range(0, 99) < gap_pct) && cyc < deadline) begin
          set_src(sel, 1'b0, b);
          @(posedge ap_clk); #1;
          if (g > 0) g--;
        end
      end
      set_src(sel, 1'b1, b);
      do begin
        @(negedge ap_clk);
        acc = sel ? s_b_tready : s_a_tready;
        @(posedge ap_clk); #1;
      end while (!acc && cyc < deadline);
      k = b.l ? 0 : k + 1;
    end
    set_src(sel, 1'b0, '0);
  endtask

  task automatic drive_sink;
    while (exp_q.size() > 0 && cyc < deadline) begin
      if (stall_len > 0 && out_cnt == stall_after && m_tvalid) begin
        m_tready = 0;
        repeat (stall_len) @(posedge ap_clk);
        #1 stall_len = 0;
      end else begin
        m_tready = ($urandom_range(0, 99) < rdy_pct);
        @(posedge ap_clk); #1;
      end
    end
    m_tready = 1;
  endtask

  task automatic monitor;
    obeat_t e, hd;
    bit held = 0;
    while (exp_q.size() > 0 && cyc < deadline) begin
      @(negedge ap_clk);
      if (held) begin
        checks++;
        if (!m_tvalid || {m_tid, m_tdata, m_tlast} !== hd) begin
          errors++;
          $display("FAIL stall_hold: got v=%0b %h required v=1 %h", m_tvalid, {m_tid, m_tdata, m_tlast}, hd);
        end
      end
      if (m_tvalid && !m_tready) begin
        stall_seen++;
        checks++;
        if (s_a_tready !== 1'b0 || s_b_tready !== 1'b0) begin
          errors++;
          $display("FAIL stall_tready: a=%0b b=%0b required 0 0", s_a_tready, s_b_tready);
        end
      end
      held = m_tvalid && !m_tready;
      hd = {m_tid, m_tdata, m_tlast};
      if (m_tvalid && m_tready) begin
        e = exp_q.pop_front();
        checks++;
        if ({m_tid, m_tdata, m_tlast} !== e) begin
          errors++;
          $display("FAIL beat %0d: tid/data/last %0b %h %0b required %0b %h %0b",
                   out_cnt, m_tid, m_tdata, m_tlast, e.t, e.d, e.l);
        end
        out_cnt++;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout: %0d beats missing required 0", exp_q.size());
    end
  endtask

  task automatic run_traffic;
    build_exp();
    out_cnt = 0; stall_seen = 0;
    deadline = cyc + 4000;
    fork
      drive_src(1'b0);
      drive_src(1'b1);
      drive_sink();
      monitor();
    join
    m_tready = 1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if (m_tvalid !== 1'b0) begin errors++; $display("FAIL extra_beat: m_tvalid=%0b required 0", m_tvalid); end
    checks++;
    if (pkt_cnt_a !== CW'(pk_a)) begin errors++; $display("FAIL cnt_a: %0d required %0d", pkt_cnt_a, CW'(pk_a)); end
    checks++;
    if (pkt_cnt_b !== CW'(pk_b)) begin errors++; $display("FAIL cnt_b: %0d required %0d", pkt_cnt_b, CW'(pk_b)); end
    last_a = src_a; last_b = src_b;
    src_a.delete(); src_b.delete();
  endtask

  task automatic test_reset;
    ap_rst_n = 0;
    @(posedge ap_clk); #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tid, m_tdata, s_a_tready, s_b_tready, pkt_cnt_a, pkt_cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%0b l=%0b id=%0b d=%h ra=%0b rb=%0b ca=%0d cb=%0d required all 0",
               m_tvalid, m_tlast, m_tid, m_tdata, s_a_tready, s_b_tready, pkt_cnt_a, pkt_cnt_b);
    end
    checks++;
    if (m_tkeep !== '1) begin errors++; $display("FAIL tkeep: %b required all ones", m_tkeep); end
    do_reset();
    m_tready = 1;
    repeat (3) @(negedge ap_clk);
    checks++;
    if (m_tvalid !== 1'b0 || s_a_tready !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet: m_tvalid=%0b s_a_tready=%0b required 0 0", m_tvalid, s_a_tready);
    end
  endtask

  task automatic test_two_pkts;
    int first = -1;
    logic [DW+2:0] want;
    do_reset(); cfg(100, 0, -1, 0, 0, 0);
    add_pkts(1'b0, 1, 1); src_a.delete(); pk_a = 0;
    for (int j = 0; j < 3; j++) begin
      src_a.push_back({DW'(16'hA000 + j), j == 2});
      src_b.push_back({DW'(16'hB000 + j), j == 2});
    end
    pk_a = 1; pk_b = 1;
    trace.delete(); trace_en = 1;
    run_traffic();
    trace_en = 0;
    foreach (trace[i]) if (first < 0 && trace[i][DW+2]) first = i;
    checks++;
    if (first != 2) begin errors++; $display("FAIL first_beat_cycle: %0d required 2", first); end
    if (first < 0) first = 0;
    for (int i = 0; i < 7; i++) begin
      want = (i < 3) ? {1'b1, 1'b0, last_a[i].d, last_a[i].l} :
             (i > 3) ? {1'b1, 1'b1, last_b[i-4].d, last_b[i-4].l} : '0;
      checks++;
      if ((i == 3) ? (trace[first+i][DW+2] !== 1'b0) : (trace[first+i] !== want)) begin
        errors++;
        $display("FAIL two_pkt_seq[%0d]: %h required %h", i, trace[first+i], want);
      end
    end
  endtask

  task automatic test_back_to_back;
    do_reset(); cfg(100, 0, -1, 0, 0, 0);
    add_pkts(1'b0, 4, 1);
    add_pkts(1'b1, 4, 1);
    run_traffic();
  endtask

  task automatic test_stall;
    do_reset(); cfg(100, 0, -1, 0, 2, 5);
    for (int j = 0; j < 6; j++) src_a.push_back({DW'($urandom), j == 5});
    pk_a = 1;
    add_pkts(1'b1, 1, 2);
    run_traffic();
    checks++;
    if (stall_seen < 5) begin errors++; $display("FAIL stall_cycles: %0d required >=5", stall_seen); end
  endtask

  task automatic test_gap;
    do_reset(); cfg(100, 0, 2, 4, 0, 0);
    for (int j = 0; j < 5; j++) src_a.push_back({DW'($urandom), j == 4});
    pk_a = 1;
    add_pkts(1'b1, 2, 3);
    run_traffic();
  endtask

  task automatic test_wrap;
    do_reset(); cfg(80, 10, -1, 0, 0, 0);
    add_pkts(1'b0, 17, 3);
    run_traffic();
    checks++;
    if (pkt_cnt_a !== 4'd1) begin errors++; $display("FAIL wrap_cnt_a: %0d required 1", pkt_cnt_a); end
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      do_reset(); cfg(60, 25, -1, 0, 0, 0);
      add_pkts(1'b0, $urandom_range(3, 8), 6);
      add_pkts(1'b1, $urandom_range(3, 8), 6);
      run_traffic();
    end
  endtask

  task automatic test_async_reset;
    do_reset(); cfg(100, 0, -1, 0, 0, 0);
    add_pkts(1'b0, 1, 1);
    run_traffic();
    s_b_tvalid = 1; s_b_tdata = 16'hBEEF; s_b_tlast = 0; m_tready = 1;
    for (int i = 0; i < 10 && !m_tvalid; i++) @(negedge ap_clk);
    checks++;
    if (m_tvalid !== 1'b1 || m_tid !== 1'b1) begin
      errors++;
      $display("FAIL midpkt_setup: v=%0b id=%0b required 1 1", m_tvalid, m_tid);
    end
    #2 ap_rst_n = 0;
    #1;
    checks++;
    if ({m_tvalid, m_tlast, m_tid, m_tdata, s_a_tready, s_b_tready} !== '0) begin
      errors++;
      $display("FAIL async_reset_out: v=%0b l=%0b id=%0b d=%h ra=%0b rb=%0b required all 0",
               m_tvalid, m_tlast, m_tid, m_tdata, s_a_tready, s_b_tready);
    end
    checks++;
    if (pkt_cnt_a !== '0 || pkt_cnt_b !== '0) begin
      errors++;
      $display("FAIL async_reset_cnt: a=%0d b=%0d required 0 0", pkt_cnt_a, pkt_cnt_b);
    end
    s_b_tvalid = 0;
    @(posedge ap_clk);
    #1 ap_rst_n = 1;
    pk_a = 0; pk_b = 0;
    add_pkts(1'b1, 1, 4);
    add_pkts(1'b0, 1, 3);
    run_traffic();
  endtask

  initial begin
    test_reset();
    test_two_pkts();
    test_back_to_back();
    test_stall();
    test_gap();
    test_wrap();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
